// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared state encodings and field widths for the program loader
package program_loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int HDR_W      = 32;
  localparam int COUNT_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_DATA   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } loadState_t;

  // Any nonzero upper half already makes the 32-bit header exceed the depth.
  function automatic logic hdrOverDepth(input logic [HDR_W-1:0] hdr, input int depth);
    return hdr > HDR_W'($unsigned(depth));
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// rtl/byte_assembler.sv - packs little-endian bytes into 32-bit words with a wordDone strobe
module byte_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  output logic [31:0] word,
  output logic        wordDone
);

  logic [1:0]  byteCnt;
  logic [23:0] shiftReg;

  // The 4th byte completes the word combinationally so the FSM can act on the same edge.
  assign wordDone = byteValid && (byteCnt == 2'(WORD_BYTES - 1));
  assign word     = {byteIn, shiftReg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byteCnt  <= '0;
      shiftReg <= '0;
    end else if (clear) begin
      byteCnt  <= '0;
      shiftReg <= '0;
    end else if (byteValid) begin
      byteCnt  <= byteCnt + 2'd1;
      shiftReg <= {byteIn, shiftReg[23:8]};
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - loads a counted word image from a byte stream into instruction memory
module program_loader
  import program_loader_pkg::*;
#(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                loadReq,
  input  logic [7:0]          rxData,
  input  logic                rxValid,
  output logic                rxReady,
  output logic                imemWrEn,
  output logic [31:0]         imemWrAddr,
  output logic [31:0]         imemWrData,
  output logic                programLoaded,
  output logic                programStart,
  output logic                loadError,
  output logic [COUNT_W-1:0]  wordsLoaded
);

  loadState_t         state;
  logic [COUNT_W-1:0] wordCount;
  logic [HDR_W-1:0]   asmWord;
  logic               asmDone;
  logic               accept;

  // loadReq wins over a byte handshaked in the same cycle.
  assign accept = rxValid && rxReady && !loadReq;

  byte_assembler u_assembler (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (loadReq),
    .byteIn    (rxData),
    .byteValid (accept),
    .word      (asmWord),
    .wordDone  (asmDone)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      wordCount     <= '0;
      rxReady       <= 1'b0;
      imemWrEn      <= 1'b0;
      imemWrAddr    <= '0;
      imemWrData    <= '0;
      programLoaded <= 1'b0;
      programStart  <= 1'b0;
      loadError     <= 1'b0;
      wordsLoaded   <= '0;
    end else begin
      imemWrEn     <= 1'b0;
      programStart <= 1'b0;
      if (loadReq) begin
        state         <= ST_HEADER;
        rxReady       <= 1'b1;
        wordCount     <= '0;
        wordsLoaded   <= '0;
        programLoaded <= 1'b0;
        loadError     <= 1'b0;
      end else begin
        case (state)
          ST_HEADER: begin
            if (asmDone) begin
              if (asmWord == '0) begin
                state         <= ST_DONE;
                rxReady       <= 1'b0;
                programLoaded <= 1'b1;
                programStart  <= 1'b1;
              end else if (hdrOverDepth(asmWord, IMEM_DEPTH)) begin
                state     <= ST_ERROR;
                rxReady   <= 1'b0;
                loadError <= 1'b1;
              end else begin
                state     <= ST_DATA;
                wordCount <= asmWord[COUNT_W-1:0];
              end
            end
          end
          ST_DATA: begin
            if (asmDone) begin
              state      <= ST_WRITE;
              rxReady    <= 1'b0;
              imemWrEn   <= 1'b1;
              imemWrData <= asmWord;
              imemWrAddr <= BASE_ADDR + {14'd0, wordsLoaded, 2'b00};
            end
          end
          ST_WRITE: begin
            wordsLoaded <= wordsLoaded + 16'd1;
            if (wordsLoaded + 16'd1 == wordCount) begin
              state         <= ST_DONE;
              programLoaded <= 1'b1;
              programStart  <= 1'b1;
            end else begin
              state   <= ST_DATA;
              rxReady <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader
module tb_program_loader;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        loadReq = 1'b0;
  logic [7:0]  rxData = 8'h00;
  logic        rxValid = 1'b0;
  logic        rxReady, imemWrEn, programLoaded, programStart, loadError;
  logic [31:0] imemWrAddr, imemWrData;
  logic [15:0] wordsLoaded;

  int nCompared = 0;
  int nFail = 0;
  int cycleNo = 0;
  int lastWrCycle = 0;
  logic [63:0] wrLog[$];
  int startLog[$];

  always #5 clk = ~clk;

  program_loader #(.IMEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .loadReq(loadReq), .rxData(rxData), .rxValid(rxValid),
    .rxReady(rxReady), .imemWrEn(imemWrEn), .imemWrAddr(imemWrAddr), .imemWrData(imemWrData),
    .programLoaded(programLoaded), .programStart(programStart), .loadError(loadError),
    .wordsLoaded(wordsLoaded)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycleNo);
    end
  endtask

  // Reference model: transaction view of the stream (byte queue, header, words written).
  bit          mActive = 0, mGotHdr = 0, mWriteNow = 0, mLoaded = 0, mStart = 0, mErr = 0;
  bit          mRxReady = 0, mWn = 0;
  int          mN = 0, mCnt = 0;
  logic [31:0] mWrAddr = '0, mWrData = '0, mW = '0;
  logic [7:0]  mPart[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mActive = 0; mGotHdr = 0; mWriteNow = 0; mLoaded = 0; mStart = 0; mErr = 0;
      mRxReady = 0; mN = 0; mCnt = 0; mWrAddr = '0; mWrData = '0;
      mPart.delete();
    end else begin
      mWn = 0;
      mStart = 0;
      if (loadReq) begin
        mActive = 1; mGotHdr = 0; mCnt = 0; mLoaded = 0; mErr = 0;
        mPart.delete();
      end else if (mWriteNow) begin
        mCnt++;
        if (mCnt == mN) begin
          mLoaded = 1; mStart = 1; mActive = 0;
        end
      end else if (mRxReady && rxValid) begin
        mPart.push_back(rxData);
        if (mPart.size() == 4) begin
          mW = {mPart[3], mPart[2], mPart[1], mPart[0]};
          mPart.delete();
          if (!mGotHdr) begin
            if (mW == 0) begin
              mLoaded = 1; mStart = 1; mActive = 0;
            end else if (mW > DEPTH) begin
              mErr = 1; mActive = 0;
            end else begin
              mGotHdr = 1; mN = int'(mW);
            end
          end else begin
            mWn = 1; mWrData = mW; mWrAddr = BASE + 32'(mCnt) * 32'd4;
          end
        end
      end
      mWriteNow = mWn;
      mRxReady = mActive && !mWn;
    end
  end

  always @(negedge clk) begin
    cycleNo++;
    chk("rxReady", {31'd0, rxReady}, {31'd0, mRxReady});
    chk("imemWrEn", {31'd0, imemWrEn}, {31'd0, mWriteNow});
    chk("imemWrAddr", imemWrAddr, mWrAddr);
    chk("imemWrData", imemWrData, mWrData);
    chk("programLoaded", {31'd0, programLoaded}, {31'd0, mLoaded});
    chk("programStart", {31'd0, programStart}, {31'd0, mStart});
    chk("loadError", {31'd0, loadError}, {31'd0, mErr});
    chk("wordsLoaded", {16'd0, wordsLoaded}, 32'(mCnt));
    if (imemWrEn) begin
      wrLog.push_back({imemWrAddr, imemWrData});
      lastWrCycle = cycleNo;
    end
    if (programStart) startLog.push_back(cycleNo);
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic pulseLoad();
    loadReq = 1'b1;
    cyc();
    loadReq = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int maxGap);
    int  g;
    int  guard;
    bit  acc;
    g = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
    rxValid = 1'b0;
    repeat (g) begin
      rxData = 8'($urandom);
      cyc();
    end
    rxData = b;
    rxValid = 1'b1;
    acc = 0;
    guard = 0;
    while (!acc && guard < 40) begin
      acc = rxReady;
      cyc();
      guard++;
    end
    if (!acc) begin
      nCompared++;
      nFail++;
      $display("FAIL sendByte_timeout: byte %h never accepted", b);
    end
    rxValid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w, input int maxGap);
    for (int i = 0; i < 4; i++) sendByte(w[8*i +: 8], maxGap);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (2) cyc();
    chk("rst_rxReady", {31'd0, rxReady}, 32'd0);
    chk("rst_loaded", {31'd0, programLoaded}, 32'd0);
    chk("rst_words", {16'd0, wordsLoaded}, 32'd0);
    rst_n = 1'b1;
    rxValid = 1'b1;
    repeat (3) begin rxData = 8'($urandom); cyc(); end
    rxValid = 1'b0;
    chk("idle_rxReady", {31'd0, rxReady}, 32'd0);

    // Two words back to back
    wrLog.delete(); startLog.delete();
    pulseLoad();
    sendWord(32'd2, 0);
    sendWord(32'h1122_3344, 0);
    sendWord(32'hAABB_CCDD, 0);
    repeat (3) cyc();
    chk("t1_nwrites", wrLog.size(), 32'd2);
    if (wrLog.size() >= 2) begin
      chk("t1_addr0", wrLog[0][63:32], 32'h0);
      chk("t1_data0", wrLog[0][31:0], 32'h1122_3344);
      chk("t1_addr1", wrLog[1][63:32], 32'h4);
      chk("t1_data1", wrLog[1][31:0], 32'hAABB_CCDD);
    end
    chk("t1_words", {16'd0, wordsLoaded}, 32'd2);
    chk("t1_loaded", {31'd0, programLoaded}, 32'd1);
    chk("t1_nstarts", startLog.size(), 32'd1);
    if (startLog.size() >= 1) chk("t1_start_lat", startLog[0], lastWrCycle + 1);
    chk("t1_model_cnt", 32'(mCnt), 32'd2);

    // Reload from DONE
    startLog.delete();
    pulseLoad();
    chk("t6_loaded_fell", {31'd0, programLoaded}, 32'd0);
    sendWord(32'd2, 3);
    sendWord(32'($urandom), 3);
    chk("t6_no_start_yet", startLog.size(), 32'd0);
    sendWord(32'($urandom), 3);
    repeat (3) cyc();
    chk("t6_nstarts", startLog.size(), 32'd1);

    // Empty image
    wrLog.delete();
    pulseLoad();
    sendWord(32'd0, 0);
    chk("t2_start", {31'd0, programStart}, 32'd1);
    chk("t2_loaded", {31'd0, programLoaded}, 32'd1);
    cyc();
    chk("t2_start_low", {31'd0, programStart}, 32'd0);
    chk("t2_nwrites", wrLog.size(), 32'd0);

    // Over-depth headers
    pulseLoad();
    sendWord(32'd257, 0);
    cyc();
    chk("t3_error", {31'd0, loadError}, 32'd1);
    chk("t3_rxReady", {31'd0, rxReady}, 32'd0);
    chk("t3_nwrites", wrLog.size(), 32'd0);
    rxValid = 1'b1;
    repeat (2) cyc();
    rxValid = 1'b0;
    pulseLoad();
    chk("t3_error_clr", {31'd0, loadError}, 32'd0);
    chk("t3_header_rdy", {31'd0, rxReady}, 32'd1);
    sendWord(32'h0001_0002, 0);
    chk("t3_upper_err", {31'd0, loadError}, 32'd1);

    // Abort mid-word, loadReq colliding with a byte handshake
    pulseLoad();
    sendWord(32'd3, 5);
    sendByte(8'h12, 5);
    sendByte(8'h34, 5);
    wrLog.delete();
    rxData = 8'h77; rxValid = 1'b1; loadReq = 1'b1;
    cyc();
    loadReq = 1'b0; rxValid = 1'b0;
    sendWord(32'd1, 5);
    sendWord(32'hDEAD_BEEF, 5);
    repeat (3) cyc();
    chk("t4_nwrites", wrLog.size(), 32'd1);
    if (wrLog.size() >= 1) begin
      chk("t4_addr", wrLog[0][63:32], BASE);
      chk("t4_data", wrLog[0][31:0], 32'hDEAD_BEEF);
    end
    chk("t4_words", {16'd0, wordsLoaded}, 32'd1);

    // Reset during the write of word 5
    pulseLoad();
    sendWord(32'd8, 2);
    for (int i = 0; i < 5; i++) sendWord(32'($urandom), 2);
    chk("t5_in_write", {31'd0, imemWrEn}, 32'd1);
    chk("t5_words4", {16'd0, wordsLoaded}, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_wren0", {31'd0, imemWrEn}, 32'd0);
    chk("t5_rdy0", {31'd0, rxReady}, 32'd0);
    chk("t5_words0", {16'd0, wordsLoaded}, 32'd0);
    chk("t5_addr0", imemWrAddr, 32'd0);
    chk("t5_data0", imemWrData, 32'd0);
    chk("t5_flags0", {29'd0, programLoaded, programStart, loadError}, 32'd0);
    cyc();
    rst_n = 1'b1;
    wrLog.delete();
    rxValid = 1'b1;
    repeat (8) begin rxData = 8'($urandom); cyc(); end
    rxValid = 1'b0;
    chk("t5_no_writes", wrLog.size(), 32'd0);

    // Exactly full memory
    pulseLoad();
    wrLog.delete();
    sendWord(32'(DEPTH), 0);
    for (int i = 0; i < DEPTH; i++) sendWord(32'($urandom), 0);
    repeat (3) cyc();
    chk("t7_nwrites", wrLog.size(), 32'(DEPTH));
    if (wrLog.size() == DEPTH) chk("t7_last_addr", wrLog[DEPTH-1][63:32], 32'h0000_03FC);
    chk("t7_words", {16'd0, wordsLoaded}, 32'd256);
    chk("t7_loaded", {31'd0, programLoaded}, 32'd1);

    // Random loads
    repeat (20) begin
      pulseLoad();
      if ($urandom_range(0, 5) == 0) begin
        sendWord(32'(DEPTH + 1 + $urandom_range(0, 50)), 3);
      end else begin
        n = int'($urandom_range(0, 6));
        sendWord(32'(n), 3);
        for (int i = 0; i < n; i++) sendWord(32'($urandom), 3);
      end
      repeat (int'($urandom_range(1, 4))) cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
    $finish;
  end

endmodule
